// File: rtl/phase_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// phase_seq_pkg
// Shared types and constants for the multicycle stage sequencer.
//   seq_state_t   : sequencer FSM states (IDLE, STEP, MWAIT)
//   STG_*         : stage indices of the default five-stage pipeline
//   MAX_STAGES    : widest stage vector the sequencer supports
//   stage_onehot  : one-hot encoding of a stage index
// ----------------------------------------------------------------------------
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        MWAIT = 2'd2
    } seq_state_t;

    localparam int STG_FT = 0;
    localparam int STG_DC = 1;
    localparam int STG_EX = 2;
    localparam int STG_MA = 3;
    localparam int STG_WB = 4;

    localparam int MAX_STAGES = 16;

    // One-hot vector with bit 'idx' set. Callers keep the low NSTAGE bits.
    function automatic logic [MAX_STAGES-1:0] stage_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// phase_seq_if
// Control/handshake bundle between the stage sequencer and the core.
//   run, flush, skip_ma, mem_ack        : core -> sequencer
//   mem_req, stage_en, stage_idx, busy,
//   retire, retire_cnt, timeout_err     : sequencer -> core
//   stall_cnt (PHASE_SEQ_PERF_EN only)  : sequencer -> core
// modport master : the sequencer side
// modport slave  : the core side
// ----------------------------------------------------------------------------
interface phase_seq_if #(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
);
    localparam int IDX_W = $clog2(NSTAGE);

    logic              run;
    logic              flush;
    logic              skip_ma;
    logic              mem_ack;
    logic              mem_req;
    logic [NSTAGE-1:0] stage_en;
    logic [IDX_W-1:0]  stage_idx;
    logic              busy;
    logic              retire;
    logic [CNT_W-1:0]  retire_cnt;
    logic              timeout_err;
`ifdef PHASE_SEQ_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        input  run, flush, skip_ma, mem_ack,
        output mem_req, stage_en, stage_idx, busy, retire, retire_cnt,
               timeout_err, stall_cnt
    );
    modport slave (
        output run, flush, skip_ma, mem_ack,
        input  mem_req, stage_en, stage_idx, busy, retire, retire_cnt,
               timeout_err, stall_cnt
    );
`else
    modport master (
        input  run, flush, skip_ma, mem_ack,
        output mem_req, stage_en, stage_idx, busy, retire, retire_cnt,
               timeout_err
    );
    modport slave (
        output run, flush, skip_ma, mem_ack,
        input  mem_req, stage_en, stage_idx, busy, retire, retire_cnt,
               timeout_err
    );
`endif

endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// ----------------------------------------------------------------------------
// seq_wait_timer
// TO_W-bit cycle counter for the memory wait state.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : count this cycle
//   expired    : this is the (2**TO_W-1)-th consecutive counted cycle
// ----------------------------------------------------------------------------
module seq_wait_timer #(
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The counter holds the number of cycles already counted, so the cycle
    // in which it reads 2**TO_W-2 is the (2**TO_W-1)-th counted cycle.
    localparam logic [TO_W-1:0] LAST_CNT = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] ONE_CNT  = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] count_r;

    // Wait-cycle counter with clear priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TO_W{1'b0}};
        end else if (clr) begin
            count_r <= {TO_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + ONE_CNT;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en & ~clr & (count_r == LAST_CNT);

endmodule

// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer
// Multicycle stage sequencer for the RV32I core: one-hot stage enables on the
// core clock, memory wait handshake with timeout, MA skip, flush and a retire
// counter.
//   CLK : core clock
//   RST : asynchronous active-low reset
//   bus : phase_seq_if.master (run/flush/skip_ma/mem_ack in; mem_req,
//         stage_en, stage_idx, busy, retire, retire_cnt, timeout_err out)
// Optional feature macro: PHASE_SEQ_PERF_EN adds bus.stall_cnt, a wrapping
// count of MWAIT cycles without mem_ack.
// ----------------------------------------------------------------------------
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NSTAGE   = 5,
    parameter int MA_STAGE = 3,
    parameter int CNT_W    = 32,
    parameter int TO_W     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    phase_seq_if.master bus
);

    localparam int IDX_W = $clog2(NSTAGE);

    localparam logic [IDX_W-1:0] IDX_FT      = IDX_W'(STG_FT);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PRE_MA  = IDX_W'(MA_STAGE - 1);
    localparam logic [IDX_W-1:0] IDX_MA      = IDX_W'(MA_STAGE);
    localparam logic [IDX_W-1:0] IDX_POST_MA = IDX_W'(MA_STAGE + 1);
    localparam logic [IDX_W-1:0] IDX_WB      = IDX_W'(NSTAGE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage-enable vector for a stage index, trimmed to NSTAGE bits.
    function automatic logic [NSTAGE-1:0] en_of(input logic [IDX_W-1:0] idx);
        logic [MAX_STAGES-1:0] full_v;
        full_v = stage_onehot(4'(idx));
        return full_v[NSTAGE-1:0];
    endfunction

    seq_state_t        state_r;
    logic [IDX_W-1:0]  stage_idx_r;
    logic [NSTAGE-1:0] stage_en_r;
    logic              busy_r;
    logic              mem_req_r;
    logic [CNT_W-1:0]  retire_cnt_r;
    logic              timeout_err_r;

    logic flush_s;
    logic wb_s;
    logic timer_clr_s;
    logic timer_en_s;
    logic timer_expired_s;

    // A flush has no effect while idle.
    assign flush_s     = bus.flush & (state_r != IDLE);
    assign wb_s        = (state_r == STEP) & (stage_idx_r == IDX_WB);
    assign timer_en_s  = (state_r == MWAIT);
    assign timer_clr_s = (state_r != MWAIT) | bus.flush | bus.mem_ack;

    seq_wait_timer #(
        .TO_W (TO_W)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // Sequencer FSM: stage stepping, memory wait, flush, timeout, retire count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= IDLE;
            stage_idx_r   <= IDX_FT;
            stage_en_r    <= {NSTAGE{1'b0}};
            busy_r        <= 1'b0;
            mem_req_r     <= 1'b0;
            retire_cnt_r  <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else if (flush_s) begin
            // Abandon the instruction without retiring it.
            mem_req_r   <= 1'b0;
            stage_idx_r <= IDX_FT;
            if (bus.run) begin
                state_r    <= STEP;
                stage_en_r <= en_of(IDX_FT);
                busy_r     <= 1'b1;
            end else begin
                state_r    <= IDLE;
                stage_en_r <= {NSTAGE{1'b0}};
                busy_r     <= 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    stage_idx_r <= IDX_FT;
                    if (bus.run && !timeout_err_r) begin
                        state_r    <= STEP;
                        stage_en_r <= en_of(IDX_FT);
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        stage_en_r <= {NSTAGE{1'b0}};
                        busy_r     <= 1'b0;
                    end
                end
                STEP: begin
                    if (stage_idx_r == IDX_WB) begin
                        retire_cnt_r <= retire_cnt_r + CNT_ONE;
                        stage_idx_r  <= IDX_FT;
                        if (bus.run) begin
                            state_r    <= STEP;
                            stage_en_r <= en_of(IDX_FT);
                            busy_r     <= 1'b1;
                        end else begin
                            state_r    <= IDLE;
                            stage_en_r <= {NSTAGE{1'b0}};
                            busy_r     <= 1'b0;
                        end
                    end else if ((stage_idx_r == IDX_PRE_MA) && !bus.skip_ma) begin
                        state_r     <= MWAIT;
                        stage_idx_r <= IDX_MA;
                        stage_en_r  <= en_of(IDX_MA);
                        mem_req_r   <= 1'b1;
                    end else if (stage_idx_r == IDX_PRE_MA) begin
                        // No memory access: jump straight past MA.
                        stage_idx_r <= IDX_POST_MA;
                        stage_en_r  <= en_of(IDX_POST_MA);
                    end else begin
                        stage_idx_r <= stage_idx_r + IDX_ONE;
                        stage_en_r  <= en_of(stage_idx_r + IDX_ONE);
                    end
                end
                MWAIT: begin
                    // Ack is checked first so it beats a same-cycle timeout.
                    if (bus.mem_ack) begin
                        state_r     <= STEP;
                        stage_idx_r <= IDX_POST_MA;
                        stage_en_r  <= en_of(IDX_POST_MA);
                        mem_req_r   <= 1'b0;
                    end else if (timer_expired_s) begin
                        state_r       <= IDLE;
                        stage_idx_r   <= IDX_FT;
                        stage_en_r    <= {NSTAGE{1'b0}};
                        busy_r        <= 1'b0;
                        mem_req_r     <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        state_r   <= MWAIT;
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    stage_idx_r <= IDX_FT;
                    stage_en_r  <= {NSTAGE{1'b0}};
                    busy_r      <= 1'b0;
                    mem_req_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHASE_SEQ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Stall counter: MWAIT cycles without ack, independent of flush.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == MWAIT) && !bus.mem_ack) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`endif

    assign bus.stage_en    = stage_en_r;
    assign bus.stage_idx   = stage_idx_r;
    assign bus.busy        = busy_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.retire_cnt  = retire_cnt_r;
    assign bus.timeout_err = timeout_err_r;
    // A flush landing on the writeback cycle suppresses that cycle's pulse.
    assign bus.retire      = wb_s & ~bus.flush;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised multicycle stage sequencer for the RV32I core. It replaces derived per-stage clocks with one-hot stage enables on the single core clock. It generalises the fixed FT/DC/EX/MA/WB sequence to NSTAGE stages, adds a memory wait handshake with timeout, skips the MA stage for non-memory instructions, supports flush, and counts retired instructions. It sits beside pc/register/mmu and gates their updates.

Parameters:
NSTAGE, 5, number of stages; stage 0 = fetch, stage NSTAGE-1 = writeback; legal range 3..16
MA_STAGE, 3, index of the memory stage; legal range 1..NSTAGE-2
CNT_W, 32, retire counter width
TO_W, 8, wait-timeout counter width; timeout fires after 2**TO_W-1 wait cycles

Ports:
CLK  in  1  core clock
RST  in  1  reset, asynchronous, active-low
run  in  1  1 = keep issuing instructions
flush  in  1  abort current instruction, restart at stage 0
skip_ma  in  1  current instruction has no memory access; sampled in stage MA_STAGE-1
mem_ack  in  1  memory access complete (wait handshake)
mem_req  out  1  memory access request, held through MA stage until ack
stage_en  out  NSTAGE  one-hot stage enable; all-zero when idle
stage_idx  out  $clog2(NSTAGE)  current stage index
busy  out  1  instruction in flight
retire  out  1  one-cycle pulse in the writeback cycle
retire_cnt  out  CNT_W  retired instruction count
timeout_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (RST=0, async): state IDLE. stage_en=0, stage_idx=0, busy=0, mem_req=0, retire=0, retire_cnt=0, timeout_err=0, wait timer=0.
- States: IDLE, STEP (non-MA stage), MWAIT (in MA stage with mem_req=1).
- IDLE: when run=1 and timeout_err=0, the next cycle is stage 0 (stage_en=1, busy=1). Otherwise remain in IDLE.
- STEP: every stage other than MA lasts exactly 1 cycle, then stage_idx increments.
- Stage MA_STAGE-1 with skip_ma=1: the next stage is MA_STAGE+1 and mem_req is never raised.
- Entering MA: go to MWAIT with mem_req=1 and stage_en[MA_STAGE]=1. The sequencer holds there while mem_ack=0.
- mem_ack=1 sampled in MWAIT: the next cycle is MA_STAGE+1 and mem_req=0.
- mem_ack=1 in the first MA cycle gives MA a 1-cycle duration. mem_ack outside MWAIT is ignored.
- Minimum latency is NSTAGE cycles per instruction, or NSTAGE-1 when MA is skipped. With defaults this is 5, or 4 when skipped.
- Writeback stage (NSTAGE-1): retire=1 for that cycle and retire_cnt increments, wrapping modulo 2**CNT_W. Next cycle is stage 0 if run=1, else IDLE.
- Deasserting run mid-instruction does not abort; the instruction completes and retires.
- flush=1 (priority over everything except reset): next cycle is stage 0 if run=1, else IDLE.
  - mem_req drops and the wait timer clears.
  - No retire pulse, even if flush coincides with the writeback stage.
  - flush in IDLE is a no-op.
- Timeout: the wait timer counts cycles in MWAIT and clears on leaving MWAIT. When it reaches 2**TO_W-1 with mem_ack still 0:
  - timeout_err=1 (sticky until reset).
  - Next state is IDLE and mem_req=0; no retire.
  - No further issue occurs while timeout_err=1.
- flush and mem_ack in the same cycle: flush wins.
- mem_ack on the cycle the timeout fires: the ack wins and no error is raised.

Optional Feature:
PHASE_SEQ_PERF_EN:
- Defined: adds output stall_cnt [CNT_W-1:0].
  - Increments once per MWAIT cycle in which mem_ack=0, wrapping.
  - Resets to 0.
  - Unaffected by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package phase_seq_pkg:
  - Enum seq_state_t {IDLE, STEP, MWAIT}.
  - Default stage index constants STG_FT=0, STG_DC=1, STG_EX=2, STG_MA=3, STG_WB=4.
  - Helper function for one-hot encoding of a stage index.
- Sub-module seq_wait_timer:
  - Function: TO_W-bit counter with clear, count enable, and an expired output.
  - Instantiated once for the MA wait.

Test Plan:
1. Defaults, run=1, skip_ma=0, mem_ack=1 whenever mem_req=1 -> stage_en cycles 00001, 00010, 00100, 01000, 10000 repeating; retire every 5th cycle; retire_cnt=4 after 20 cycles.
2. skip_ma=1 sampled in EX -> sequence FT, DC, EX, WB; mem_req never 1; retire every 4th cycle.
3. mem_ack held 0 for 7 cycles, then 1 -> stage_en=01000 and mem_req=1 for 8 cycles; WB follows; with PHASE_SEQ_PERF_EN, stall_cnt=7.
4. TO_W=4, mem_ack stuck 0 -> after 15 MWAIT cycles timeout_err=1, stage_en=0, busy=0; no retire; run=1 does not restart until RST pulsed low.
5. flush=1 during MWAIT and again during WB -> the next cycle is stage 0 each time; mem_req=0; retire_cnt unchanged.
6. RST low asynchronously mid-MWAIT, between clock edges -> all outputs reach reset values immediately; after release with run=1, fetch restarts at stage 0 and retire_cnt=0.
